// File: rtl/taillight_seq_ctrl_if.sv
// Switch inputs and lamp outputs of the tail-light controller.
// The master side drives the switches; the slave side (the controller) drives the lamps.
interface taillight_seq_ctrl_if #(
  parameter int LAMPS = 3
);
  logic                 haz;
  logic                 left;
  logic                 right;
  logic                 brake;
  logic [2*LAMPS-1:0]   tl_led;
  logic                 tick;

  modport master (output haz, left, right, brake, input tl_led, tick);
  modport slave  (input haz, left, right, brake, output tl_led, tick);
endinterface

// File: rtl/taillight_seq_ctrl.sv
// Sequential tail-light controller: turn sweep, hazard flash and brake overlay,
// stepped by a built-in prescaler tick.
module taillight_seq_ctrl #(
  parameter int LAMPS = 3,
  parameter int DIV   = 4166666,
  parameter int CW    = 23
) (
  input  logic               clk,
  input  logic               rst_n,
  taillight_seq_ctrl_if.slave io
);
  localparam int SW = $clog2(LAMPS + 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(LAMPS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, LSWEEP, RSWEEP, HAZ_ON, HAZ_OFF} state_t;

  // sync bit order: {haz, left, right, brake}
  logic [3:0]          sync1_q, sync2_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  state_t              state_q, state_d;
  logic [SW-1:0]       step_q, step_d;
  logic [2*LAMPS-1:0]  led_q, led_d;
  logic                tick, hs, ls, rs, bs, hz;
  logic [LAMPS-1:0]    mask, lamp_l, lamp_r;

  assign hs = sync2_q[3];
  assign ls = sync2_q[2];
  assign rs = sync2_q[1];
  assign bs = sync2_q[0];
  assign hz = hs | (ls & rs);

  assign tick      = (cnt_q == CNT_MAX);
  assign io.tick   = tick;
  assign io.tl_led = led_q;

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (tick) begin
      if (hz) begin
        state_d = (state_q == HAZ_ON) ? HAZ_OFF : HAZ_ON;
        step_d  = '0;
      end else if (ls) begin
        state_d = LSWEEP;
        if (state_q == LSWEEP) step_d = (step_q == STEP_MAX) ? '0 : step_q + 1'b1;
        else                   step_d = SW'(1);
      end else if (rs) begin
        state_d = RSWEEP;
        if (state_q == RSWEEP) step_d = (step_q == STEP_MAX) ? '0 : step_q + 1'b1;
        else                   step_d = SW'(1);
      end else begin
        state_d = IDLE;
        step_d  = '0;
      end
    end
  end

  // Lamps are computed from the next state so FSM changes land on the tick edge.
  always_comb begin
    mask   = '0;
    lamp_l = '0;
    lamp_r = '0;
    led_d  = '0;
    for (int i = 0; i < LAMPS; i++) mask[i] = (step_d > SW'(i));
    case (state_d)
      LSWEEP:  begin lamp_l = mask;          lamp_r = {LAMPS{bs}}; end
      RSWEEP:  begin lamp_l = {LAMPS{bs}};   lamp_r = mask;        end
      HAZ_ON:  begin lamp_l = '1;            lamp_r = '1;          end
      HAZ_OFF: begin lamp_l = '0;            lamp_r = '0;          end
      default: begin lamp_l = {LAMPS{bs}};   lamp_r = {LAMPS{bs}}; end
    endcase
    for (int i = 0; i < LAMPS; i++) begin
      led_d[LAMPS+i]   = lamp_l[i];
      led_d[LAMPS-1-i] = lamp_r[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      step_q  <= '0;
      led_q   <= '0;
    end else begin
      sync1_q <= {io.haz, io.left, io.right, io.brake};
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      step_q  <= step_d;
      led_q   <= led_d;
    end
  end
endmodule

// File: tb/tb_taillight_seq_ctrl.sv
// Directed bench for taillight_seq_ctrl with LAMPS=3, DIV=4.
module tb_taillight_seq_ctrl;
  logic clk, rst_n;
  int   n_pass = 0, n_fail = 0, n_total = 0;

  taillight_seq_ctrl_if #(.LAMPS(3)) io ();
  taillight_seq_ctrl #(.LAMPS(3), .DIV(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .io(io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance to the negedge just after the next tick edge.
  task automatic next_tick();
    int k;
    k = 0;
    while (io.tick !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (io.tick !== 1'b1) begin
      n_total++;
      n_fail++;
      $error("FAIL tick_timeout observed=0 expected=1");
    end
    @(negedge clk);
  endtask

  task automatic tick_chk(input string tag, input logic [5:0] exp);
    next_tick();
    chk(tag, {2'b00, io.tl_led}, {2'b00, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    io.haz = 0; io.left = 0; io.right = 0; io.brake = 0;

    // 1: reset and tick cadence
    @(negedge clk);
    chk("rst_led", {2'b00, io.tl_led}, 8'h00);
    chk("rst_tick", {7'd0, io.tick}, 8'h00);
    #2 rst_n = 1'b1;
    @(negedge clk); chk("t1_e1_tick", {7'd0, io.tick}, 8'h00);
    @(negedge clk); chk("t1_e2_tick", {7'd0, io.tick}, 8'h00);
    @(negedge clk); chk("t1_e3_tick", {7'd0, io.tick}, 8'h01);
    @(negedge clk); chk("t1_e4_tick", {7'd0, io.tick}, 8'h00);
    chk("t1_e4_led", {2'b00, io.tl_led}, 8'h00);
    @(negedge clk); @(negedge clk);
    chk("t1_e6_tick", {7'd0, io.tick}, 8'h00);
    @(negedge clk); chk("t1_e7_tick", {7'd0, io.tick}, 8'h01);
    next_tick();

    // 2: left sweep, then release mid-sweep
    io.left = 1;
    tick_chk("t2_s1", 6'b001000);
    tick_chk("t2_s2", 6'b011000);
    tick_chk("t2_s3", 6'b111000);
    tick_chk("t2_gap", 6'b000000);
    tick_chk("t2_s1b", 6'b001000);
    tick_chk("t2_s2b", 6'b011000);
    io.left = 0;
    tick_chk("t2_rel", 6'b000000);

    // 3: right sweep with brake arriving mid-sweep
    io.right = 1;
    tick_chk("t3_s1", 6'b000100);
    tick_chk("t3_s2", 6'b000110);
    io.brake = 1;
    @(negedge clk); @(negedge clk);
    chk("t3_brk_e2", {2'b00, io.tl_led}, 8'b00000110);
    @(negedge clk);
    chk("t3_brk_e3", {2'b00, io.tl_led}, 8'b00111110);
    tick_chk("t3_s3", 6'b111111);
    tick_chk("t3_gap", 6'b111000);
    io.right = 0; io.brake = 0;
    tick_chk("t3_rel", 6'b000000);

    // 4: hazard aborts a sweep; both turns act as hazard; brake ignored
    io.left = 1;
    tick_chk("t4_s1", 6'b001000);
    tick_chk("t4_s2", 6'b011000);
    io.haz = 1;
    tick_chk("t4_h_on", 6'b111111);
    tick_chk("t4_h_off", 6'b000000);
    tick_chk("t4_h_on2", 6'b111111);
    io.brake = 1;
    tick_chk("t4_hb_off", 6'b000000);
    tick_chk("t4_hb_on", 6'b111111);
    io.haz = 0; io.right = 1;
    tick_chk("t4_lr_off", 6'b000000);
    tick_chk("t4_lr_on", 6'b111111);
    io.left = 0; io.right = 0; io.brake = 0;
    tick_chk("t4_rel", 6'b000000);

    // 5: direction change mid-sweep, then brake alone in IDLE
    io.left = 1;
    tick_chk("t5_s1", 6'b001000);
    tick_chk("t5_s2", 6'b011000);
    io.left = 0; io.right = 1;
    tick_chk("t5_dir", 6'b000100);
    io.right = 0;
    tick_chk("t5_idle", 6'b000000);
    io.brake = 1;
    @(negedge clk); @(negedge clk);
    chk("t5_brk_e2", {2'b00, io.tl_led}, 8'h00);
    @(negedge clk);
    chk("t5_brk_e3", {2'b00, io.tl_led}, 8'b00111111);
    @(negedge clk); @(negedge clk);
    io.brake = 0;
    @(negedge clk); @(negedge clk);
    chk("t5_rel_e2", {2'b00, io.tl_led}, 8'b00111111);
    @(negedge clk);
    chk("t5_rel_e3", {2'b00, io.tl_led}, 8'h00);

    // 6: asynchronous reset mid-hazard
    io.haz = 1;
    tick_chk("t6_on", 6'b111111);
    tick_chk("t6_off", 6'b000000);
    tick_chk("t6_on2", 6'b111111);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_led", {2'b00, io.tl_led}, 8'h00);
    chk("t6_async_tick", {7'd0, io.tick}, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); chk("t6_e1_tick", {7'd0, io.tick}, 8'h00);
    chk("t6_e1_led", {2'b00, io.tl_led}, 8'h00);
    @(negedge clk); chk("t6_e2_tick", {7'd0, io.tick}, 8'h00);
    @(negedge clk); chk("t6_e3_tick", {7'd0, io.tick}, 8'h01);
    chk("t6_e3_led", {2'b00, io.tl_led}, 8'h00);
    @(negedge clk); chk("t6_e4_led", {2'b00, io.tl_led}, 8'b00111111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
